// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control sequencer for the 16-bit datapath
// Optional feature macro: MVNZ_EN (opcode 6 executes as mvnz; otherwise it halts)
module mc_control_fsm #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    input  logic                  g_nz,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            addr_sel,
    output logic [2:0]            bus_sel,
    output logic                  rf_we,
    output logic [2:0]            rf_waddr,
    output logic [2:0]            rf_raddr_x,
    output logic [2:0]            rf_raddr_y,
    output logic                  a_load,
    output logic                  g_load,
    output logic                  alu_op,
    output logic                  pc_inc,
    output logic                  instr_done,
    output logic                  halted,
    output logic [15:0]           instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IMM, S_EX1, S_EX2, S_MEM, S_HALT
    } state_t;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVNZ = 4'd6;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] ir;
    logic                  fetch_busy;
    logic                  fetch_active;
    logic [3:0]            opcode;
    logic                  op_legal;
    logic                  unused_bits;

    assign opcode = ir[15:12];

    // Once a fetch request is outstanding it is held until ack even if run drops.
    assign fetch_active = fetch_busy | run;

`ifdef MVNZ_EN
    assign op_legal    = (opcode <= OP_MVNZ);
    assign unused_bits = ^ir[5:0];
`else
    assign op_legal    = (opcode <= OP_ST);
    assign unused_bits = ^{ir[5:0], g_nz};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir          <= '0;
            fetch_busy  <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            if (state == S_FETCH && fetch_active && mem_ack) begin
                ir <= mem_rdata;
            end
            fetch_busy <= (state == S_FETCH) && fetch_active && !mem_ack;
            if (instr_done) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (!fetch_active)  state_next = S_IDLE;
                else if (mem_ack)   state_next = S_DECODE;
            end
            S_DECODE: begin
                if (!op_legal) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode)
                        OP_MVI:         state_next = S_IMM;
                        OP_ADD, OP_SUB: state_next = S_EX1;
                        OP_LD, OP_ST:   state_next = S_MEM;
                        default:        state_next = S_FETCH;
                    endcase
                end
            end
            S_IMM: begin
                if (mem_ack) state_next = S_FETCH;
            end
            S_EX1:   state_next = S_EX2;
            S_EX2:   state_next = S_FETCH;
            S_MEM: begin
                if (mem_ack) state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 2'b00;
        bus_sel    = 3'b000;
        rf_we      = 1'b0;
        rf_waddr   = 3'd0;
        rf_raddr_x = 3'd0;
        rf_raddr_y = 3'd0;
        a_load     = 1'b0;
        g_load     = 1'b0;
        alu_op     = 1'b0;
        pc_inc     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;

        if (state != S_IDLE && state != S_HALT) begin
            rf_waddr   = ir[11:9];
            rf_raddr_x = ir[11:9];
            rf_raddr_y = ir[8:6];
        end

        case (state)
            S_FETCH: begin
                if (fetch_active) begin
                    mem_req = 1'b1;
                    pc_inc  = mem_ack;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    case (opcode)
                        OP_MV: begin
                            rf_we      = 1'b1;
                            instr_done = 1'b1;
                        end
`ifdef MVNZ_EN
                        OP_MVNZ: begin
                            rf_we      = g_nz;
                            instr_done = 1'b1;
                        end
`endif
                        OP_ADD, OP_SUB: begin
                            bus_sel = 3'b001;
                            a_load  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_IMM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    bus_sel    = 3'b011;
                    rf_we      = 1'b1;
                    pc_inc     = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_EX1: begin
                alu_op = ir[12];
                g_load = 1'b1;
            end
            S_EX2: begin
                bus_sel    = 3'b010;
                rf_we      = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 2'b01;
                if (opcode == OP_ST) begin
                    // Store data (rX) stays on the bus for the whole request.
                    mem_we     = 1'b1;
                    bus_sel    = 3'b001;
                    instr_done = mem_ack;
                end else if (mem_ack) begin
                    bus_sel    = 3'b011;
                    rf_we      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized bench for mc_control_fsm against an ISA-level model
module tb_mc_control_fsm;

`ifdef MVNZ_EN
    localparam int MAX_OP = 6;
`else
    localparam int MAX_OP = 5;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ack = 1'b0;
    logic        g_nz;
    logic        mem_req, mem_we, rf_we, a_load, g_load, alu_op, pc_inc, instr_done, halted;
    logic [1:0]  addr_sel;
    logic [2:0]  bus_sel, rf_waddr, rf_raddr_x, rf_raddr_y;
    logic [15:0] instr_count;

    mc_control_fsm #(.DATA_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .g_nz(g_nz), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .bus_sel(bus_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_raddr_x(rf_raddr_x), .rf_raddr_y(rf_raddr_y), .a_load(a_load),
        .g_load(g_load), .alu_op(alu_op), .pc_inc(pc_inc), .instr_done(instr_done),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [38:0] all_out;
    assign all_out = {mem_req, mem_we, addr_sel, bus_sel, rf_we, rf_waddr, rf_raddr_x,
                      rf_raddr_y, a_load, g_load, alu_op, pc_inc, instr_done, halted, instr_count};

    // Datapath and memory that obey the controller's select/enable outputs.
    logic [15:0] r [8];
    logic [15:0] dmem [256];
    logic [15:0] init_r [8];
    logic [15:0] init_d [256];
    logic [15:0] a_reg, g_reg, pc, bus;
    logic [15:0] prog [$];
    int          wplan [$];
    int          wq [$];

    assign g_nz = (g_reg != 16'd0);

    always_comb begin
        case (bus_sel)
            3'b000:  bus = r[rf_raddr_y];
            3'b001:  bus = r[rf_raddr_x];
            3'b010:  bus = g_reg;
            3'b011:  bus = mem_rdata;
            default: bus = 16'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) r[i] <= init_r[i];
            for (int i = 0; i < 256; i++) dmem[i] <= init_d[i];
            a_reg <= 16'd0;
            g_reg <= 16'd0;
            pc    <= 16'd0;
        end else begin
            if (rf_we)  r[rf_waddr] <= bus;
            if (a_load) a_reg <= bus;
            if (g_load) g_reg <= alu_op ? a_reg - bus : a_reg + bus;
            if (pc_inc) pc <= pc + 16'd1;
            if (mem_req && mem_ack && mem_we) dmem[r[rf_raddr_y][7:0]] <= bus;
        end
    end

    // Memory responder: each request waits the number of cycles taken from wq.
    int         wcnt = 0;
    int         cur_wait = 0;
    bit         have_wait = 1'b0;
    logic [2:0] cap_req;

    always @(negedge clk) begin
        if (mem_ack) begin
            have_wait = 1'b0;
            wcnt      = 0;
        end
        if (mem_req) begin
            if (!have_wait) begin
                cur_wait  = (wq.size() > 0) ? wq.pop_front() : 0;
                have_wait = 1'b1;
                wcnt      = 0;
                cap_req   = {mem_we, addr_sel};
            end else begin
                check_eq("req_stable", {mem_we, addr_sel}, cap_req);
            end
            if (addr_sel == 2'b00)
                mem_rdata = (int'(pc) < prog.size()) ? prog[pc] : 16'hF000;
            else
                mem_rdata = dmem[r[rf_raddr_y][7:0]];
            if (wcnt == cur_wait) begin
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            have_wait = 1'b0;
            wcnt      = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    task automatic run_prog();
        logic [15:0] mr [8];
        logic [15:0] md [256];
        logic [15:0] mg, ir;
        logic [2:0]  x, y;
        int          mpc, wi, n, last, t, cyc;
        bit          halt_exp;
        int          exp_cyc [$];

        for (int i = 0; i < 8; i++) begin
            init_r[i] = 16'($urandom);
            mr[i]     = init_r[i];
        end
        init_r[2][0] = 1'b1;
        mr[2]        = init_r[2];
        for (int i = 0; i < 256; i++) begin
            init_d[i] = 16'($urandom);
            md[i]     = init_d[i];
        end

        mg = 16'd0; mpc = 0; wi = 0; halt_exp = 1'b0;
        while (mpc < prog.size() && !halt_exp) begin
            ir  = prog[mpc];
            x   = ir[11:9];
            y   = ir[8:6];
            mpc++;
            cyc = 2 + wplan[wi];
            wi++;
            case (int'(ir[15:12]))
                0: mr[x] = mr[y];
                1: begin mr[x] = prog[mpc]; mpc++; cyc += 1 + wplan[wi]; wi++; end
                2: begin mg = mr[x] + mr[y]; mr[x] = mg; cyc += 2; end
                3: begin mg = mr[x] - mr[y]; mr[x] = mg; cyc += 2; end
                4: begin mr[x] = md[mr[y][7:0]]; cyc += 1 + wplan[wi]; wi++; end
                5: begin md[mr[y][7:0]] = mr[x]; cyc += 1 + wplan[wi]; wi++; end
`ifdef MVNZ_EN
                6: if (mg != 16'd0) mr[x] = mr[y];
`endif
                default: halt_exp = 1'b1;
            endcase
            if (!halt_exp) exp_cyc.push_back(cyc);
        end

        run     = 1'b0;
        reset_n = 1'b0;
        wq      = wplan;
        @(negedge clk); #1;
        check_eq("reset_outputs", all_out, 39'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;

        n = 0; last = 0;
        foreach (exp_cyc[k]) begin
            t = 0;
            do begin
                @(negedge clk); #1;
                n++; t++;
            end while (!instr_done && t < 64);
            check_eq("instr_done_seen", instr_done, 1'b1);
            check_eq("instr_cycles", n - last, exp_cyc[k]);
            check_eq("count_at_done", instr_count, k);
            last = n;
            if (k == exp_cyc.size() - 1 && !halt_exp) run = 1'b0;
        end

        if (halt_exp) begin
            t = 0;
            while (!halted && t < 64) begin
                @(negedge clk); #1;
                t++;
            end
            check_eq("halted", halted, 1'b1);
            check_eq("count_after_halt", instr_count, exp_cyc.size());
            repeat (6) @(negedge clk);
            #1;
            check_eq("halt_sticky", {halted, mem_req, instr_done, rf_we}, 4'b1000);
        end else begin
            @(negedge clk); #1;
            check_eq("fetch_no_req_run0", mem_req, 1'b0);
            @(negedge clk); #1;
            check_eq("idle_outputs", all_out[38:16], 23'd0);
            check_eq("final_count", instr_count, exp_cyc.size());
        end

        for (int i = 0; i < 8; i++) check_eq($sformatf("reg_r%0d", i), r[i], mr[i]);
        for (int i = 0; i < 256; i++) check_eq("dmem", dmem[i], md[i]);
        check_eq("pc", pc, mpc);
    endtask

    task automatic reset_mid_fetch();
        prog    = {16'h0440};
        wq      = {3};
        run     = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;
        @(negedge clk); #1;
        check_eq("fetch_req", mem_req, 1'b1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_eq("async_req_drop", mem_req, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_after_reset", all_out, 39'd0);
        check_eq("pc_not_advanced", pc, 16'd0);
    endtask

    task automatic gen_prog(input int n, input bit end_illegal);
        logic [15:0] w;
        int          op;
        prog.delete();
        wplan.delete();
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, MAX_OP);
            w  = 16'($urandom);
            w[15:12] = 4'(op);
            prog.push_back(w);
            wplan.push_back($urandom_range(0, 3));
            if (op == 1 || op == 4 || op == 5) wplan.push_back($urandom_range(0, 3));
            if (op == 1) prog.push_back(16'($urandom));
        end
        if (end_illegal) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(7, 15));
            prog.push_back(w);
            wplan.push_back($urandom_range(0, 3));
        end
    endtask

    initial begin
        reset_mid_fetch();

        prog = {16'h0440};                      wplan = {0};          run_prog();
        prog = {16'h3280};                      wplan = {2};          run_prog();
        prog = {16'h5040};                      wplan = {0, 3};       run_prog();
        prog = {16'h1600, 16'hBEEF, 16'h4A40};  wplan = {1, 1, 0, 2}; run_prog();
`ifdef MVNZ_EN
        prog = {16'h6200, 16'h2480, 16'h6200};  wplan = {0, 0, 0};    run_prog();
`else
        prog = {16'h0440, 16'h6200};            wplan = {0, 0};       run_prog();
`endif
        prog = {16'hF000};                      wplan = {0};          run_prog();

        for (int p = 0; p < 5; p++) begin
            gen_prog(16, p == 4);
            run_prog();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control sequencer for the 16-bit processor datapath. It fetches instruction words through a req/ack memory handshake, holds the current instruction in an internal instruction register (IR), and steps each instruction through a fixed state sequence. Each cycle it drives the datapath controls: bus and address mux selects, register-file write, the A/G register loads, ALU op and PC control. It sits directly upstream of the datapath muxes and registers and is their only source of select and enable signals.

## Interface
- `DATA_WIDTH`, 16, instruction/data word width.
- `clk` input 1 — single clock; all state changes on rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `run` input 1 — start/continue execution; sampled in IDLE and FETCH.
- `mem_rdata` input DATA_WIDTH — memory read data, valid when `mem_ack`=1.
- `mem_ack` input 1 — memory completes the current request this cycle.
- `g_nz` input 1 — G register is nonzero (datapath flag).
- `mem_req` output 1 — memory request; held until `mem_ack`.
- `mem_we` output 1 — request is a write.
- `addr_sel` output 2 — memory address select: 00 = PC, 01 = rY.
- `bus_sel` output 3 — bus select: 000 = rY, 001 = rX, 010 = G, 011 = mem_rdata, 100 = zero.
- `rf_we` output 1 — register-file write enable.
- `rf_waddr` output 3 — write address (always IR[11:9], rX).
- `rf_raddr_x` / `rf_raddr_y` output 3 each — IR[11:9] / IR[8:6].
- `a_load`, `g_load` output 1 each — load A from bus; load G from ALU.
- `alu_op` output 1 — 0 = add, 1 = sub (A op bus).
- `pc_inc` output 1 — PC += 1 at this edge.
- `instr_done` output 1 — one-cycle pulse in an instruction's final cycle.
- `halted` output 1 — illegal opcode seen; sticky until reset.
- `instr_count` output 16 — retired-instruction counter.

## Operation
- Opcode is IR[15:12]: 0 mv, 1 mvi, 2 add, 3 sub, 4 ld, 5 st, 6 mvnz; 7–15 are illegal.
- States: IDLE, FETCH, DECODE, IMM, EX1, EX2, MEM, HALT.
- IDLE: all outputs 0.
  - `run`=1 → FETCH.
- FETCH: `mem_req`=1, `addr_sel`=00.
  - Stays in FETCH until `mem_ack`.
  - On ack: IR ← `mem_rdata`, `pc_inc`=1 → DECODE.
  - If `run`=0 on entry, returns to IDLE without issuing `mem_req`.
- DECODE, by opcode:
  - mv: `bus_sel`=000, `rf_we` → FETCH.
  - mvnz: as mv when `g_nz`=1; no write when `g_nz`=0.
  - mvi → IMM.
  - add/sub: `bus_sel`=001, `a_load` → EX1.
  - ld/st → MEM.
  - illegal → HALT.
- IMM: `mem_req`, `addr_sel`=00, waits for ack.
  - On ack: `bus_sel`=011, `rf_we`, `pc_inc` → FETCH.
- EX1: `bus_sel`=000, `alu_op`=IR[12], `g_load` → EX2.
- EX2: `bus_sel`=010, `rf_we` → FETCH.
- MEM: `mem_req`, `addr_sel`=01, waits for ack.
  - ld: on ack, `bus_sel`=011 and `rf_we`.
  - st: `mem_we`=1 and `bus_sel`=001 for the whole request.
  - → FETCH.
- HALT: `halted`=1; all other outputs 0; leaves only on reset.
- `instr_done` is asserted in the final state of each instruction.
  - `instr_count` increments (mod 2^16) on that edge.
  - An illegal opcode does not count.

## Timing
- Outputs are combinational from state, IR, `mem_ack` and `g_nz`. State, IR and counter are registered.
- Reset values: state IDLE, IR 0, `instr_count` 0, `halted` 0; every output 0.
- Reset mid-request drops `mem_req` asynchronously; no pending write completes afterwards.
- Cycles with zero wait states (ack in the same cycle as req):
  - mv/mvnz: 2.
  - mvi, ld, st: 3.
  - add/sub: 4.
- Each wait cycle adds one cycle.
- `mem_req`, `mem_we` and `addr_sel` are stable from request to ack. `mem_ack` with `mem_req`=0 is ignored.
- `run` deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE from FETCH.

## Configuration
- `MVNZ_EN` defined: opcode 6 executes as mvnz.
- `MVNZ_EN` undefined: opcode 6 is illegal → HALT; `g_nz` is unused.

## Test plan
- Reset low mid-FETCH with `mem_req`=1 → `mem_req`=0 immediately; state IDLE and `instr_count`=0 after release.
- Fetch 0x0440 (mv r2,r1) with 0 waits → DECODE has `bus_sel`=000, `rf_we`=1, `rf_waddr`=2; `instr_done` in cycle 2; count=1.
- Fetch 0x3280 (sub r1,r2) with 2 fetch wait states → `a_load`, then `g_load` with `alu_op`=1, then `rf_we` with `bus_sel`=010; 6 cycles total.
- Fetch 0x5040 (st r0,[r1]) with ack delayed 3 cycles → `mem_we`=1, `addr_sel`=01, `bus_sel`=001 held all 4 MEM cycles.
- Fetch 0x6200 with `g_nz`=0, then with `g_nz`=1 → no write, then a write. With `MVNZ_EN` undefined → `halted`=1 and `instr_count` unchanged.
- Fetch 0xF000 → HALT; `halted` stays 1 with `run`=1 until `reset_n`=0.
